lock_monitor: RTL and testbench

LOCK_MONITOR -- requirements
Module: lock_monitor

---
 rtl/lock_monitor.sv | 140 ++++++++++++++
 tb/tb_lock_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_monitor.sv
// PLL lock monitor: synchronizes `locked`, waits for a stable window, releases reset.
// Optional build macro LOCK_MONITOR_GLITCH_FILTER_EN: in RUN, ignore lock drops shorter than 4 cycles.
module lock_monitor #(
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    output logic       rst_out_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_lost_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    state_t cur;
    state_t nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   loss;

    // Metastability chain for the asynchronous lock indicator.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef LOCK_MONITOR_GLITCH_FILTER_EN
    logic [1:0] flt;
    logic [1:0] flt_nxt;

    // Loss only after four consecutive low cycles in RUN; any high clears the count.
    always_comb begin
        flt_nxt = 2'd0;
        loss    = 1'b0;
        if (cur == RUN && !lock_s) begin
            if (flt == 2'd3) begin
                loss = 1'b1;
            end else begin
                flt_nxt = flt + 2'd1;
            end
        end
    end

    // Filter run-length register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            flt <= 2'd0;
        end else begin
            flt <= flt_nxt;
        end
    end
`else
    // Any single low cycle in RUN is a loss.
    always_comb begin
        loss = (cur == RUN) && !lock_s;
    end
`endif

    // Next-state and stabilize-counter logic.
    always_comb begin
        nxt     = cur;
        cnt_nxt = '0;
        unique case (cur)
            WAIT_LOCK: begin
                if (lock_s) nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s) begin
                    nxt = WAIT_LOCK;
                end else if (cnt == LAST) begin
                    nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (loss) nxt = FAULT;
            end
            FAULT: begin
                nxt = WAIT_LOCK;
            end
            default: begin
                nxt = WAIT_LOCK;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cur <= WAIT_LOCK;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    // Registered reset release and ready, both tied to entering RUN.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            rst_out_n <= (nxt == RUN);
            ready     <= (nxt == RUN);
        end
    end

    // Saturating loss counter, bumped on the edge that enters FAULT.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_lost_count <= 8'd0;
        end else if (cur == RUN && loss && lock_lost_count != 8'hFF) begin
            lock_lost_count <= lock_lost_count + 8'd1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_lock_monitor.sv
// Self-checking bench for lock_monitor with a run-length reference model.
// Directed scenarios pin the model; random lock patterns exercise the rest.
module tb_lock_monitor;

    localparam int N = 8;
    localparam int S = 2;
`ifdef LOCK_MONITOR_GLITCH_FILTER_EN
    localparam int LOSS_LEN = 4;
    localparam int FILT     = 1;
`else
    localparam int LOSS_LEN = 1;
    localparam int FILT     = 0;
`endif

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic       locked   = 1'b0;
    logic       rst_out_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_lost_count;

    int errors = 0;
    int checks = 0;

    lock_monitor #(
        .STABLE_CYCLES(N),
        .SYNC_STAGES  (S)
    ) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .locked         (locked),
        .rst_out_n      (rst_out_n),
        .ready          (ready),
        .state          (state),
        .lock_lost_count(lock_lost_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: lock_s is `locked` delayed S edges; pre-RUN progress
    // is the run length of consecutive high lock_s samples (1 = stabilize
    // started, N+1 = window complete); in RUN, LOSS_LEN consecutive lows fault.
    int m_state = 0;
    int m_lost  = 0;
    int hi_run  = 0;
    int lo_run  = 0;
    bit m_sync[S];
    bit ls;

    always @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0;
            m_lost  = 0;
            hi_run  = 0;
            lo_run  = 0;
            for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
        end else begin
            ls = m_sync[S-1];
            for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = locked;
            if (m_state == 3) begin
                m_state = 0;
                hi_run  = 0;
            end else if (m_state == 2) begin
                lo_run = ls ? 0 : lo_run + 1;
                if (lo_run >= LOSS_LEN) begin
                    m_state = 3;
                    lo_run  = 0;
                    if (m_lost < 255) m_lost = m_lost + 1;
                end
            end else begin
                hi_run = ls ? hi_run + 1 : 0;
                if (hi_run == 0) m_state = 0;
                else if (hi_run >= N + 1) m_state = 2;
                else m_state = 1;
                lo_run = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clock_in) begin
        chk("state", state, m_state);
        chk("ready", ready, int'(m_state == 2));
        chk("rst_out_n", rst_out_n, int'(m_state == 2));
        chk("lost_count", lock_lost_count, m_lost);
    end

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_ready", ready, 0);
        chk("async_rst_rstout", rst_out_n, 0);
        chk("async_rst_count", lock_lost_count, 0);
        @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    // k = edges from the first sampling edge to the rst_out_n rise, -1 on timeout.
    task automatic measure_rise(output int k);
        k = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock_in);
            #1;
            if (rst_out_n === 1'b1) begin
                k = i - 1;
                break;
            end
        end
    endtask

    task automatic wait_run();
        for (int i = 0; i < 60; i++) begin
            @(negedge clock_in);
            if (ready === 1'b1) break;
        end
        chk("run_reached", ready, 1);
    endtask

    initial begin
        int k;
        int len;
        bit saw_fault;

        repeat (3) @(negedge clock_in);
        reset_n = 1'b1;
        chk("reset_state", state, 0);
        chk("reset_rstout", rst_out_n, 0);
        chk("reset_ready", ready, 0);
        chk("reset_count", lock_lost_count, 0);
        repeat (3) @(negedge clock_in);
        chk("idle_wait", state, 0);

        // Clean lock: 10-edge latency.
        locked = 1'b1;
        measure_rise(k);
        chk("latency_clean", k, 10);
        chk("model_run_clean", m_state, 2);
        chk("ready_clean", ready, 1);

        // One-cycle glitch in RUN.
        @(negedge clock_in);
        locked = 1'b0;
        @(negedge clock_in);
        locked = 1'b1;
        saw_fault = 1'b0;
        repeat (6) begin
            @(negedge clock_in);
            if (state === 2'd3) saw_fault = 1'b1;
        end
        chk("fault_1cyc", saw_fault, 1 - FILT);
        chk("lost_1cyc", lock_lost_count, 1 - FILT);
        wait_run();

        // Four-cycle drop in RUN.
        @(negedge clock_in);
        locked = 1'b0;
        repeat (4) @(negedge clock_in);
        locked = 1'b1;
        repeat (8) @(negedge clock_in);
        chk("lost_4cyc", lock_lost_count, 2 - FILT);
        wait_run();

        // Drop during stabilize restarts the window.
        @(negedge clock_in);
        do_reset();
        locked = 1'b0;
        @(negedge clock_in);
        locked = 1'b1;
        repeat (5) @(negedge clock_in);
        locked = 1'b0;
        @(negedge clock_in);
        locked = 1'b1;
        measure_rise(k);
        chk("latency_relock", k, 10);

        // Reset mid-stabilize with counter at 5.
        @(negedge clock_in);
        do_reset();
        repeat (8) @(posedge clock_in);
        #1;
        chk("mid_stab_state", state, 1);
        chk("model_mid_stab", m_state, 1);
        do_reset();
        measure_rise(k);
        chk("latency_after_stab_rst", k, 10);

        // Reset mid-RUN.
        repeat (3) @(posedge clock_in);
        #1;
        do_reset();
        measure_rise(k);
        chk("latency_after_run_rst", k, 10);

        // Saturation of the loss counter.
        @(negedge clock_in);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            wait_run();
            locked = 1'b0;
            repeat (4) @(negedge clock_in);
            locked = 1'b1;
        end
        repeat (5) @(negedge clock_in);
        chk("lost_saturated", lock_lost_count, 255);
        chk("model_saturated", m_lost, 255);

        // Random lock patterns with occasional resets.
        do_reset();
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
            end else begin
                locked = ($urandom_range(0, 3) != 0);
                len = locked ? $urandom_range(1, 30) : $urandom_range(1, 6);
                repeat (len) @(negedge clock_in);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
